vid_mem_resp: RTL and testbench

Bus responder (target) for the video-bus protocol. It models the frame-buffer memory that the video controller reads pixel data from.
- Accepts register-style single writes and burst writes, then returns a write response.
- Accepts burst read requests, bids for the bus, and streams read-data beats back to the requester.
- Sits on the shared bus opposite the video controller, behind the arbiter.

---
 rtl/vid_bus_pkg.sv | 56 +++++
 rtl/vid_mem_array.sv | 36 +++
 rtl/vid_mem_resp.sv | 256 +++++++++++++++++++++++++
 tb/tb_vid_mem_resp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vid_bus_pkg.sv
// -----------------------------------------------------------------------------
// vid_bus_pkg
// Shared definitions for the video-bus responder:
//   - vid_cmd_e       : bus command encoding
//   - ST_*            : responder FSM state constants
//   - VID_REQ_TGT_DEF : default target ID driven on reqtar (video controller)
//   - len_to_beats    : burst length code -> number of beats
//   - len_to_last     : burst length code -> beats-1 (beat counter preload)
// -----------------------------------------------------------------------------
package vid_bus_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE   = 3'b000,
        CMD_WDATA  = 3'b001,
        CMD_RDREQ  = 3'b010,
        CMD_RDATA  = 3'b011,
        CMD_WRREQ  = 3'b100,
        CMD_WRRESP = 3'b101,
        CMD_ERR    = 3'b111
    } vid_cmd_e;

    localparam logic [3:0] VID_REQ_TGT_DEF = 4'h1;

    // Responder FSM states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DATA = 3'd1;
    localparam logic [2:0] ST_WR_BID  = 3'd2;
    localparam logic [2:0] ST_WR_RESP = 3'd3;
    localparam logic [2:0] ST_RD_BID  = 3'd4;
    localparam logic [2:0] ST_RD_DATA = 3'd5;

    function automatic logic [3:0] len_to_beats(input logic [1:0] len);
        logic [3:0] beats;
        case (len)
            2'd0:    beats = 4'd1;
            2'd1:    beats = 4'd2;
            2'd2:    beats = 4'd4;
            2'd3:    beats = 4'd8;
            default: beats = 4'd1;
        endcase
        return beats;
    endfunction

    function automatic logic [2:0] len_to_last(input logic [1:0] len);
        logic [2:0] last;
        case (len)
            2'd0:    last = 3'd0;
            2'd1:    last = 3'd1;
            2'd2:    last = 3'd3;
            2'd3:    last = 3'd7;
            default: last = 3'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/vid_mem_array.sv
// -----------------------------------------------------------------------------
// vid_mem_array
// Single-port DEPTH x 32 storage, synchronous write, registered read.
// Ports:
//   clk   : clock
//   we    : write enable (writes wdata to mem[idx] on posedge)
//   idx   : word index used for both read and write
//   wdata : write data
//   rdata : registered read data of mem[idx] sampled at the previous edge
// Contents are never cleared by reset.
// -----------------------------------------------------------------------------
module vid_mem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Storage write and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vid_mem_resp.sv
// -----------------------------------------------------------------------------
// vid_mem_resp
// Video-bus target modelling the frame-buffer memory. Accepts single/burst
// writes (answered with one WRRESP cycle after winning the bus) and burst
// reads (streamed back as back-to-back RDATA beats after winning the bus).
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   selin        : this target is addressed in the current request cycle
//   cmdin        : bus command in
//   lenin        : burst length code (0:1, 1:2, 2:4, 3:8 beats)
//   addrdatain   : byte address in request cycle, data in data phase
//   ackin        : arbiter grant for our bid
//   reqout       : bus bid (BID_PRI while bidding/responding, else 0)
//   lenout       : latched length code during responses
//   addrdataout  : read data / response payload
//   cmdout       : bus command out
//   reqtar       : response target (REQ_TGT while bidding/responding, else 0)
//
// Optional feature macro: VID_MEM_RESP_ERR_EN
//   When defined, requests that run past the last word or carry address bits
//   above the memory range are consumed without touching memory and answered
//   with a single ERR cycle carrying the offending address.
// -----------------------------------------------------------------------------
module vid_mem_resp
    import vid_bus_pkg::*;
#(
    parameter int         DEPTH   = 1024,
    parameter int         AW      = 10,
    parameter logic [3:0] REQ_TGT = VID_REQ_TGT_DEF,
    parameter logic [1:0] BID_PRI = 2'b11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [2:0]  cmdout,
    output logic [3:0]  reqtar
);

    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    len_q, len_d;
    logic          err_q, err_d;

    logic [1:0]    reqout_q, reqout_d;
    logic [1:0]    lenout_q, lenout_d;
    logic [31:0]   addrdataout_q, addrdataout_d;
    logic [2:0]    cmdout_q, cmdout_d;
    logic [3:0]    reqtar_q, reqtar_d;

    logic          mem_we_s;
    logic [AW-1:0] mem_idx_s;
    logic [31:0]   mem_rdata_s;
    logic [AW-1:0] req_idx_s;
    logic          req_err_s;

    assign req_idx_s = addrdatain[AW+1:2];

`ifdef VID_MEM_RESP_ERR_EN
    localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);
    logic [AW:0] req_end_s;

    // Flag requests that run past the last word or address outside the memory
    always_comb begin
        req_end_s = {1'b0, req_idx_s} + {{(AW-3){1'b0}}, len_to_beats(lenin)};
        req_err_s = (req_end_s > DEPTH_X) || (|addrdatain[31:AW+2]);
    end
`else
    assign req_err_s = 1'b0;
`endif

    // Responder FSM: next state, burst bookkeeping and next output values
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        len_d         = len_q;
        err_d         = err_q;
        mem_we_s      = 1'b0;
        reqout_d      = 2'b00;
        lenout_d      = 2'b00;
        addrdataout_d = 32'h0000_0000;
        cmdout_d      = CMD_IDLE;
        reqtar_d      = 4'h0;

        case (state_q)
            ST_IDLE: begin
                if (selin && (cmdin == CMD_WRREQ)) begin
                    idx_d   = req_idx_s;
                    cnt_d   = len_to_last(lenin);
                    addr_d  = addrdatain;
                    len_d   = lenin;
                    err_d   = req_err_s;
                    state_d = ST_WR_DATA;
                end else if (selin && (cmdin == CMD_RDREQ)) begin
                    idx_d    = req_idx_s;
                    cnt_d    = len_to_last(lenin);
                    addr_d   = addrdatain;
                    len_d    = lenin;
                    err_d    = req_err_s;
                    state_d  = ST_RD_BID;
                    reqout_d = BID_PRI;
                    reqtar_d = REQ_TGT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WR_DATA: begin
                if (cmdin == CMD_WDATA) begin
                    // Erroneous bursts still consume their beats but never write
                    mem_we_s = ~err_q;
                    idx_d    = idx_q + IDX_ONE;
                    if (cnt_q == 3'd0) begin
                        state_d  = ST_WR_BID;
                        reqout_d = BID_PRI;
                        reqtar_d = REQ_TGT;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else if (cmdin == CMD_IDLE) begin
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WR_BID: begin
                reqout_d = BID_PRI;
                reqtar_d = REQ_TGT;
                if (ackin) begin
                    state_d       = ST_WR_RESP;
                    cmdout_d      = err_q ? CMD_ERR : CMD_WRRESP;
                    addrdataout_d = addr_q;
                    lenout_d      = len_q;
                end else begin
                    state_d = ST_WR_BID;
                end
            end

            // Single response cycle (WRRESP or ERR) is on the outputs now
            ST_WR_RESP: begin
                state_d = ST_IDLE;
            end

            ST_RD_BID: begin
                reqout_d = BID_PRI;
                reqtar_d = REQ_TGT;
                if (ackin && err_q) begin
                    // Reuse the single-cycle response state for the ERR reply
                    state_d       = ST_WR_RESP;
                    cmdout_d      = CMD_ERR;
                    addrdataout_d = addr_q;
                    lenout_d      = len_q;
                end else if (ackin) begin
                    // The memory has been reading mem[idx_q] every cycle while
                    // bidding, so the first beat is ready right at the grant.
                    state_d       = ST_RD_DATA;
                    cmdout_d      = CMD_RDATA;
                    addrdataout_d = mem_rdata_s;
                    lenout_d      = len_q;
                    idx_d         = idx_q + IDX_ONE;
                end else begin
                    state_d = ST_RD_BID;
                end
            end

            ST_RD_DATA: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    reqout_d      = BID_PRI;
                    reqtar_d      = REQ_TGT;
                    cmdout_d      = CMD_RDATA;
                    addrdataout_d = mem_rdata_s;
                    lenout_d      = len_q;
                    idx_d         = idx_q + IDX_ONE;
                    cnt_d         = cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writes use the current index; otherwise prefetch the next index so the
    // registered read data always tracks idx_q.
    always_comb begin
        if (mem_we_s) begin
            mem_idx_s = idx_q;
        end else begin
            mem_idx_s = idx_d;
        end
    end

    vid_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s & ~reset),
        .idx   (mem_idx_s),
        .wdata (addrdatain),
        .rdata (mem_rdata_s)
    );

    // State, burst context and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= {AW{1'b0}};
            cnt_q         <= 3'd0;
            addr_q        <= 32'h0000_0000;
            len_q         <= 2'b00;
            err_q         <= 1'b0;
            reqout_q      <= 2'b00;
            lenout_q      <= 2'b00;
            addrdataout_q <= 32'h0000_0000;
            cmdout_q      <= 3'b000;
            reqtar_q      <= 4'h0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            err_q         <= err_d;
            reqout_q      <= reqout_d;
            lenout_q      <= lenout_d;
            addrdataout_q <= addrdataout_d;
            cmdout_q      <= cmdout_d;
            reqtar_q      <= reqtar_d;
        end
    end

    assign reqout      = reqout_q;
    assign lenout      = lenout_q;
    assign addrdataout = addrdataout_q;
    assign cmdout      = cmdout_q;
    assign reqtar      = reqtar_q;

endmodule

// File: tb/tb_vid_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_vid_mem_resp
// Self-checking bench for vid_mem_resp. A plain word array stands in for the
// frame buffer; every bus response is compared against it.
// -----------------------------------------------------------------------------
module tb_vid_mem_resp;

    localparam int N_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [31:0] addrdatain;
    logic        ackin;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [N_WORDS];
    logic [31:0] wdata_buf [8];

    always #5 clk = ~clk;

    vid_mem_resp dut (
        .clk         (clk),
        .reset       (reset),
        .selin       (selin),
        .cmdin       (cmdin),
        .lenin       (lenin),
        .addrdatain  (addrdatain),
        .ackin       (ackin),
        .reqout      (reqout),
        .lenout      (lenout),
        .addrdataout (addrdataout),
        .cmdout      (cmdout),
        .reqtar      (reqtar)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_err(input logic [31:0] addr, input logic [1:0] len);
`ifdef VID_MEM_RESP_ERR_EN
        int word  = int'(addr[11:2]);
        int beats = 1 << len;
        return ((word + beats) > N_WORDS) || (addr[31:12] != 20'h0);
`else
        return (addr == 32'hFFFF_FFFF) && (len == 2'd3) && 1'b0;
`endif
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, "_cmd"},    32'(cmdout),      32'd0);
        check_val({tag, "_req"},    32'(reqout),      32'd0);
        check_val({tag, "_tar"},    32'(reqtar),      32'd0);
        check_val({tag, "_len"},    32'(lenout),      32'd0);
        check_val({tag, "_data"},   addrdataout,      32'd0);
    endtask

    // Write burst from wdata_buf; stall_at inserts one IDLE cycle before that beat
    task automatic wr_burst(input logic [31:0] addr, input logic [1:0] len,
                            input int stall_at, input int ack_dly);
        int beats = 1 << len;
        int word  = int'((addr >> 2) % N_WORDS);
        bit err   = is_err(addr, len);
        selin = 1'b1; cmdin = 3'b100; addrdatain = addr; lenin = len;
        tick();
        selin = 1'b0; cmdin = 3'b000; addrdatain = 32'h0;
        for (int i = 0; i < beats; i++) begin
            if (i == stall_at) begin
                tick();
                check_val("wr_stall_nobid", 32'(reqout), 32'd0);
            end
            cmdin = 3'b001; addrdatain = wdata_buf[i];
            tick();
            cmdin = 3'b000; addrdatain = 32'h0;
        end
        check_val("wr_bid_req", 32'(reqout), 32'h3);
        check_val("wr_bid_tar", 32'(reqtar), 32'h1);
        for (int d = 0; d < ack_dly; d++) begin
            tick();
            check_val("wr_wait_req", 32'(reqout), 32'h3);
            check_val("wr_wait_cmd", 32'(cmdout), 32'h0);
        end
        ackin = 1'b1;
        tick();
        ackin = 1'b0;
        check_val("wr_resp_cmd",  32'(cmdout), err ? 32'h7 : 32'h5);
        check_val("wr_resp_addr", addrdataout, addr);
        check_val("wr_resp_len",  32'(lenout), 32'(len));
        check_val("wr_resp_tar",  32'(reqtar), 32'h1);
        tick();
        check_quiet("wr_after");
        if (!err) begin
            for (int i = 0; i < beats; i++) model_mem[(word + i) % N_WORDS] = wdata_buf[i];
        end
    endtask

    // Read burst; busy_req fires a second RDREQ while bidding, reset_at asserts
    // reset while that beat is on the bus
    task automatic rd_burst(input logic [31:0] addr, input logic [1:0] len, input int ack_dly,
                            input bit busy_req, input int reset_at);
        int beats = 1 << len;
        int word  = int'((addr >> 2) % N_WORDS);
        bit err   = is_err(addr, len);
        selin = 1'b1; cmdin = 3'b010; addrdatain = addr; lenin = len;
        tick();
        selin = 1'b0; cmdin = 3'b000; addrdatain = 32'h0;
        check_val("rd_bid_req", 32'(reqout), 32'h3);
        check_val("rd_bid_tar", 32'(reqtar), 32'h1);
        check_val("rd_bid_cmd", 32'(cmdout), 32'h0);
        if (busy_req) begin
            selin = 1'b1; cmdin = 3'b010; addrdatain = addr ^ 32'h40; lenin = 2'd3;
            tick();
            selin = 1'b0; cmdin = 3'b000; addrdatain = 32'h0;
            check_val("rd_busy_cmd", 32'(cmdout), 32'h0);
            check_val("rd_busy_req", 32'(reqout), 32'h3);
        end
        for (int d = 0; d < ack_dly; d++) begin
            tick();
            check_val("rd_wait_req", 32'(reqout), 32'h3);
            check_val("rd_wait_cmd", 32'(cmdout), 32'h0);
        end
        ackin = 1'b1;
        tick();
        ackin = 1'b0;
        if (err) begin
            check_val("rd_err_cmd",  32'(cmdout), 32'h7);
            check_val("rd_err_addr", addrdataout, addr);
            tick();
            check_quiet("rd_err_after");
        end else begin
            for (int i = 0; i < beats; i++) begin
                check_val("rd_beat_cmd",  32'(cmdout), 32'h3);
                check_val("rd_beat_data", addrdataout, model_mem[(word + i) % N_WORDS]);
                check_val("rd_beat_len",  32'(lenout), 32'(len));
                check_val("rd_beat_req",  32'(reqout), 32'h3);
                check_val("rd_beat_tar",  32'(reqtar), 32'h1);
                if (i == reset_at) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    check_quiet("rd_reset");
                    tick();
                    check_quiet("rd_reset_hold");
                    return;
                end
                tick();
            end
            check_quiet("rd_after");
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  l;
        int          st;

        reset = 1'b1; selin = 1'b0; cmdin = 3'b000; lenin = 2'b00;
        addrdatain = 32'h0; ackin = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        reset = 1'b0;

        // Fill the whole memory so every later read has a known expectation
        for (int b = 0; b < N_WORDS / 8; b++) begin
            for (int j = 0; j < 8; j++) wdata_buf[j] = $urandom;
            wr_burst(32'(b * 32), 2'd3, -1, 0);
        end

        // Single write then read
        wdata_buf[0] = 32'hDEAD_BEEF;
        wr_burst(32'h48, 2'd0, -1, 1);
        rd_burst(32'h48, 2'd0, 0, 1'b0, -1);
        check_val("single_model", model_mem[18], 32'hDEAD_BEEF);

        // 4-beat burst with a stall between beats 2 and 3
        wdata_buf[0] = 32'h11; wdata_buf[1] = 32'h22;
        wdata_buf[2] = 32'h33; wdata_buf[3] = 32'h44;
        wr_burst(32'h100, 2'd2, 2, 0);
        rd_burst(32'h100, 2'd2, 0, 1'b0, -1);

        // Wrap past the last word
        for (int j = 0; j < 8; j++) wdata_buf[j] = $urandom;
        wr_burst(32'((N_WORDS - 2) * 4), 2'd3, -1, 0);
        rd_burst(32'((N_WORDS - 2) * 4), 2'd0, 0, 1'b0, -1);
        rd_burst(32'((N_WORDS - 1) * 4), 2'd0, 0, 1'b0, -1);
        rd_burst(32'h0, 2'd3, 0, 1'b0, -1);

        // Delayed grant
        rd_burst(32'h200, 2'd1, 10, 1'b0, -1);

        // Request while busy is ignored
        rd_burst(32'h300, 2'd0, 2, 1'b1, -1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_quiet("busy_idle");
        end

        // Reset on the 2nd beat of an 8-beat read
        rd_burst(32'h400, 2'd3, 0, 1'b0, 1);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            a = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
            l = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 8; j++) wdata_buf[j] = $urandom;
                st = (l != 2'd0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, (1 << l) - 1) : -1;
                wr_burst(a, l, st, $urandom_range(0, 3));
            end else begin
                rd_burst(a, l, $urandom_range(0, 3), 1'b0, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
